// File: rtl/ddr3_rd_arbiter.sv
// Round-robin arbiter sharing one DDR3 read controller between two requesters,
// with a four-phase completion handshake and a hung-reader timeout.
module ddr3_rd_arbiter #(
    parameter int unsigned     TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(16_000_000)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_en,
    input  logic [22:0] req0_start_addr,
    input  logic [23:0] req0_burst_cnt,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_en,
    input  logic [22:0] req1_start_addr,
    input  logic [23:0] req1_burst_cnt,
    output logic        req1_done,
    output logic        req1_err,
    output logic [22:0] ddr3_rd_start_addr,
    output logic [23:0] ddr3_rd_burst_cnt,
    output logic        enable_reading,
    input  logic        reading_done,
    output logic        grant_valid,
    output logic        grant_id,
    output logic [7:0]  timeout_count
);

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned TC_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_READ,
        S_RELEASE,
        S_DRAIN
    } state_t;

    state_t            state, state_d;
    logic              last_grant, last_grant_d;
    logic              grant_id_d, grant_valid_d, enable_d;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              req0_done_d, req1_done_d, req0_err_d, req1_err_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic [TC_W-1:0]   timeout_count_d;
    logic              done_meta, done_s;

    logic              win;
    logic              winner_en;
    logic              to_hit;
    logic [TC_W-1:0]   tcount_inc;

    // reading_done comes from the reader's clock domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= reading_done;
            done_s    <= done_meta;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            last_grant         <= 1'b1;
            grant_id           <= 1'b0;
            grant_valid        <= 1'b0;
            enable_reading     <= 1'b0;
            ddr3_rd_start_addr <= '0;
            ddr3_rd_burst_cnt  <= '0;
            req0_done          <= 1'b0;
            req1_done          <= 1'b0;
            req0_err           <= 1'b0;
            req1_err           <= 1'b0;
            to_cnt             <= '0;
            timeout_count      <= '0;
        end else begin
            state              <= state_d;
            last_grant         <= last_grant_d;
            grant_id           <= grant_id_d;
            grant_valid        <= grant_valid_d;
            enable_reading     <= enable_d;
            ddr3_rd_start_addr <= addr_d;
            ddr3_rd_burst_cnt  <= cnt_d;
            req0_done          <= req0_done_d;
            req1_done          <= req1_done_d;
            req0_err           <= req0_err_d;
            req1_err           <= req1_err_d;
            to_cnt             <= to_cnt_d;
            timeout_count      <= timeout_count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d         = state;
        last_grant_d    = last_grant;
        grant_id_d      = grant_id;
        grant_valid_d   = grant_valid;
        enable_d        = enable_reading;
        addr_d          = ddr3_rd_start_addr;
        cnt_d           = ddr3_rd_burst_cnt;
        req0_done_d     = req0_done;
        req1_done_d     = req1_done;
        req0_err_d      = req0_err;
        req1_err_d      = req1_err;
        to_cnt_d        = to_cnt;
        timeout_count_d = timeout_count;
        win             = 1'b0;

        winner_en  = grant_id ? req1_en : req0_en;
        to_hit     = (to_cnt == TIMEOUT_CYCLES - TO_W'(1));
        tcount_inc = (timeout_count == {TC_W{1'b1}}) ? timeout_count
                                                     : timeout_count + TC_W'(1);

        case (state)
            S_IDLE: begin
                if (req0_en || req1_en) begin
                    // On a tie the requester that did not win last time goes first
                    win           = (req0_en && req1_en) ? ~last_grant : req1_en;
                    state_d       = S_GRANT;
                    grant_id_d    = win;
                    last_grant_d  = win;
                    grant_valid_d = 1'b1;
                    addr_d        = win ? req1_start_addr : req0_start_addr;
                    cnt_d         = win ? req1_burst_cnt  : req0_burst_cnt;
                    to_cnt_d      = '0;
                end
            end

            S_GRANT: begin
                if (ddr3_rd_burst_cnt == '0) begin
                    state_d     = S_RELEASE;
                    req0_done_d = ~grant_id;
                    req1_done_d = grant_id;
                    req0_err_d  = ~grant_id;
                    req1_err_d  = grant_id;
                end else begin
                    state_d  = S_READ;
                    enable_d = 1'b1;
                end
            end

            S_READ: begin
                if (done_s) begin
                    state_d     = S_RELEASE;
                    enable_d    = 1'b0;
                    req0_done_d = ~grant_id;
                    req1_done_d = grant_id;
                    req0_err_d  = 1'b0;
                    req1_err_d  = 1'b0;
                end else if (to_hit) begin
                    state_d         = S_RELEASE;
                    enable_d        = 1'b0;
                    req0_done_d     = ~grant_id;
                    req1_done_d     = grant_id;
                    req0_err_d      = ~grant_id;
                    req1_err_d      = grant_id;
                    timeout_count_d = tcount_inc;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end

            S_RELEASE: begin
                if (!winner_en) begin
                    state_d  = S_DRAIN;
                    to_cnt_d = '0;
                end
            end

            S_DRAIN: begin
                // Wait for the reader to drop done before taking a new request
                if (!done_s || to_hit) begin
                    state_d       = S_IDLE;
                    grant_valid_d = 1'b0;
                    req0_done_d   = 1'b0;
                    req1_done_d   = 1'b0;
                    req0_err_d    = 1'b0;
                    req1_err_d    = 1'b0;
                    if (done_s) begin
                        timeout_count_d = tcount_inc;
                    end
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Self-checking bench for ddr3_rd_arbiter: directed steps with randomized
// addresses, counts and request patterns checked against a round-robin model.
module tb_ddr3_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_en, req1_en;
    logic [22:0] req0_start_addr, req1_start_addr;
    logic [23:0] req0_burst_cnt, req1_burst_cnt;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [22:0] ddr3_rd_start_addr;
    logic [23:0] ddr3_rd_burst_cnt;
    logic        enable_reading;
    logic        reading_done;
    logic        grant_valid;
    logic        grant_id;
    logic [7:0]  timeout_count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: who won last, how many timeouts so far
    logic m_last;
    int   m_tcount;

    ddr3_rd_arbiter #(
        .TO_W           (24),
        .TIMEOUT_CYCLES (24'd32)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req0_en            (req0_en),
        .req0_start_addr    (req0_start_addr),
        .req0_burst_cnt     (req0_burst_cnt),
        .req0_done          (req0_done),
        .req0_err           (req0_err),
        .req1_en            (req1_en),
        .req1_start_addr    (req1_start_addr),
        .req1_burst_cnt     (req1_burst_cnt),
        .req1_done          (req1_done),
        .req1_err           (req1_err),
        .ddr3_rd_start_addr (ddr3_rd_start_addr),
        .ddr3_rd_burst_cnt  (ddr3_rd_burst_cnt),
        .enable_reading     (enable_reading),
        .reading_done       (reading_done),
        .grant_valid        (grant_valid),
        .grant_id           (grant_id),
        .timeout_count      (timeout_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return ~last;
        return r1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic wait_en(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enable_reading && n < 40);
    endtask

    task automatic wait_done(input logic id, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_done : req0_done) && n < 60);
    endtask

    task automatic wait_idle(input int exp_lat);
        int n;
        bit overlap;
        n = 0;
        overlap = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (enable_reading) overlap = 1'b1;
        end while (grant_valid && n < 60);
        check("idle_lat", 64'(n), 64'(exp_lat));
        check("no_overlap", 64'(overlap), 64'd0);
        check("idle_done_clr", 64'({req0_done, req1_done, req0_err, req1_err}), 64'd0);
    endtask

    // Observe one successful transfer for requester id; requests already driven
    task automatic serve(input logic id, input logic [22:0] a, input logic [23:0] c,
                         input int delay, input int exp_lat, input bit hold);
        int n;
        wait_en(n);
        if (exp_lat > 0) check("en_lat", 64'(n), 64'(exp_lat));
        else             check("en_seen", 64'(enable_reading), 64'd1);
        check("grant_id", 64'(grant_id), 64'(id));
        check("grant_valid", 64'(grant_valid), 64'd1);
        check("rd_addr", 64'(ddr3_rd_start_addr), 64'(a));
        check("rd_cnt", 64'(ddr3_rd_burst_cnt), 64'(c));
        repeat (delay) @(negedge clk);
        check("en_held", 64'(enable_reading), 64'd1);
        reading_done = 1'b1;
        wait_done(id, n);
        check("done_lat", 64'(n), 64'd3);
        check("done_err", 64'(id ? req1_err : req0_err), 64'd0);
        check("en_off", 64'(enable_reading), 64'd0);
        if (id) req1_en = 1'b0;
        else    req0_en = 1'b0;
        if (!hold) reading_done = 1'b0;
    endtask

    initial begin
        int n;
        bit bad;
        logic r0, r1, w;
        logic [22:0] a0, a1;
        logic [23:0] c0, c1;

        reset_n = 1'b0;
        req0_en = 1'b0; req1_en = 1'b0;
        req0_start_addr = '0; req1_start_addr = '0;
        req0_burst_cnt = '0; req1_burst_cnt = '0;
        reading_done = 1'b0;
        m_last = 1'b1;
        m_tcount = 0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_outs", 64'({ddr3_rd_start_addr, ddr3_rd_burst_cnt, enable_reading,
                                 grant_valid, grant_id, req0_done, req0_err, req1_done,
                                 req1_err, timeout_count}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request
        req0_en = 1'b1; req0_start_addr = 23'h000100; req0_burst_cnt = 24'd4;
        w = rr_pick(1'b1, 1'b0, m_last);
        serve(w, 23'h000100, 24'd4, 10, 2, 1'b0);
        m_last = w;
        wait_idle(3);

        // Random request patterns, forced ties first
        for (int k = 0; k < 8; k++) begin
            r0 = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            r1 = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            a0 = 23'($urandom); a1 = 23'($urandom);
            c0 = 24'($urandom_range(1, 5000)); c1 = 24'($urandom_range(1, 5000));
            req0_start_addr = a0; req0_burst_cnt = c0; req0_en = r0;
            req1_start_addr = a1; req1_burst_cnt = c1; req1_en = r1;
            w = rr_pick(r0, r1, m_last);
            serve(w, w ? a1 : a0, w ? c1 : c0, $urandom_range(0, 6), 2, 1'b0);
            m_last = w;
            wait_idle(3);
            if (r0 && r1) begin
                serve(~w, w ? a0 : a1, w ? c0 : c1, $urandom_range(0, 6), 2, 1'b0);
                m_last = ~w;
                wait_idle(3);
            end
        end

        // Zero burst count is rejected without enabling the reader
        req1_start_addr = 23'($urandom); req1_burst_cnt = 24'd0; req1_en = 1'b1;
        n = 0; bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (enable_reading) bad = 1'b1;
        end while (!req1_done && n < 20);
        check("zero_lat", 64'(n), 64'd2);
        check("zero_err", 64'(req1_err), 64'd1);
        check("zero_no_en", 64'(bad), 64'd0);
        check("zero_tcount", 64'(timeout_count), 64'(m_tcount));
        m_last = 1'b1;
        req1_en = 1'b0;
        wait_idle(2);

        // Reader never drops done: DRAIN expires
        a0 = 23'($urandom); c0 = 24'($urandom_range(1, 100));
        req0_start_addr = a0; req0_burst_cnt = c0; req0_en = 1'b1;
        serve(1'b0, a0, c0, 2, 2, 1'b1);
        m_last = 1'b0;
        wait_idle(33);
        m_tcount = sat_inc(m_tcount);
        check("drain_tcount", 64'(timeout_count), 64'(m_tcount));
        reading_done = 1'b0;
        repeat (3) @(negedge clk);

        // Late done while draining holds off a pending requester
        a0 = 23'($urandom); c0 = 24'($urandom_range(1, 100));
        req0_start_addr = a0; req0_burst_cnt = c0; req0_en = 1'b1;
        serve(1'b0, a0, c0, 3, 2, 1'b1);
        m_last = 1'b0;
        a1 = 23'($urandom); c1 = 24'($urandom_range(1, 100));
        req1_start_addr = a1; req1_burst_cnt = c1; req1_en = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!grant_valid || grant_id || enable_reading) bad = 1'b1;
        end
        check("late_done_hold", 64'(bad), 64'd0);
        reading_done = 1'b0;
        serve(1'b1, a1, c1, 1, 0, 1'b0);
        m_last = 1'b1;
        wait_idle(3);

        // Read timeouts, saturating the counter
        for (int i = 0; i < 300; i++) begin
            req0_start_addr = 23'($urandom); req0_burst_cnt = 24'($urandom_range(1, 1000));
            req0_en = 1'b1;
            wait_en(n);
            check("to_en_lat", 64'(n), 64'd2);
            wait_done(1'b0, n);
            check("to_lat", 64'(n), 64'd32);
            check("to_err", 64'(req0_err), 64'd1);
            m_tcount = sat_inc(m_tcount);
            check("to_tcount", 64'(timeout_count), 64'(m_tcount));
            req0_en = 1'b0;
            wait_idle(2);
        end
        m_last = 1'b0;

        // Asynchronous reset mid-READ
        a1 = 23'($urandom); c1 = 24'($urandom_range(1, 1000));
        req1_start_addr = a1; req1_burst_cnt = c1; req1_en = 1'b1;
        wait_en(n);
        check("ar_en_on", 64'(enable_reading), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_outs", 64'({enable_reading, grant_valid, req0_done, req0_err,
                              req1_done, req1_err}), 64'd0);
        check("ar_tcount", 64'(timeout_count), 64'd0);
        m_last = 1'b1;
        m_tcount = 0;
        a0 = 23'($urandom); c0 = 24'($urandom_range(1, 1000));
        req0_start_addr = a0; req0_burst_cnt = c0; req0_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        w = rr_pick(1'b1, 1'b1, m_last);
        serve(w, w ? a1 : a0, w ? c1 : c0, 4, 2, 1'b0);
        m_last = w;
        wait_idle(3);
        serve(~w, w ? a0 : a1, w ? c0 : c1, 4, 2, 1'b0);
        m_last = ~w;
        wait_idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr3_rd_arbiter.md
Name: ddr3_rd_arbiter

Overview:
- Shares the single DDR3 read controller (`ddr3_rd_control`) between two command state machines.
  - Requester 0: fill readout.
  - Requester 1: memory-dump / debug readout.
- Round-robin grant, latches the winner's start address and burst count, and drives the reader's enable.
- Relays completion back to the winner with a four-phase handshake and reports the current owner to the AXIS output mux.
- Guards against a hung reader with a timeout.

Parameters:
- TIMEOUT_CYCLES, 24'd16_000_000, cycles allowed in READ before abort.
- TO_W, 24, width of timeout counter.

Ports:
- clk  in  1  local clock
- reset_n  in  1  asynchronous, active-low reset
- req0_en  in  1  level request from requester 0; held until req0_done seen
- req0_start_addr  in  23  first 128-bit burst address, requester 0
- req0_burst_cnt  in  24  bursts to read, requester 0
- req0_done  out  1  transfer finished (or aborted) for requester 0
- req0_err  out  1  qualifies req0_done: abort/reject
- req1_en, req1_start_addr, req1_burst_cnt, req1_done, req1_err  same for requester 1
- ddr3_rd_start_addr  out  23  to reader
- ddr3_rd_burst_cnt  out  24  to reader
- enable_reading  out  1  to reader (level)
- reading_done  in  1  from reader, asynchronous to clk
- grant_valid  out  1  a requester owns the reader
- grant_id  out  1  owner index (valid with grant_valid)
- timeout_count  out  8  saturating count of timeouts since reset

Behaviour:
- Reset (reset_n low, async): state IDLE, all outputs 0, last_grant=1 (requester 0 wins first tie), timeout_count=0, synchronizer flops 0.
- reading_done passes through a 2-FF synchronizer (done_s). All decisions use done_s.
- Outputs are registered; they change on the clock edge that enters the state.

State IDLE:
- Exits when any reqN_en=1.
- Only one requesting: that one wins.
- Both requesting: the one != last_grant wins.
- Next state GRANT.

GRANT (1 cycle):
- Latch winner's addr/count into ddr3_rd_*; set grant_id, grant_valid=1, last_grant=winner; clear timeout counter.
- If latched burst_cnt==0: go to RELEASE with err=1 (reader never enabled).
- Otherwise go to READ.

READ:
- enable_reading=1; timeout counter increments each cycle.
- done_s=1: go to RELEASE, err=0.
- Counter reaches TIMEOUT_CYCLES-1 without done_s: go to RELEASE, err=1, timeout_count+1 (saturates at 255).
- done_s and timeout on the same cycle: done wins, err=0.

RELEASE:
- enable_reading=0; reqW_done=1, reqW_err as determined.
- Hold until winner's reqW_en=0, then go to DRAIN.

DRAIN:
- Wait for done_s=0, then go to IDLE.
- On entering IDLE, clear grant_valid, done and err.
- DRAIN is also bounded by the same timeout. On expiry go to IDLE, with timeout_count+1.

Other rules:
- Winner drops reqW_en before RELEASE (requester reset mid-transfer): stay in READ until done/timeout, then pass RELEASE in one cycle. No done pulse is required to be seen.
- Non-winner's req_en changing never affects the current transfer. A pending request is served next IDLE.
- ddr3_rd_* hold their last latched values outside GRANT.
- Requester-side addr/count are sampled only in GRANT.
- reset_n asserted mid-transfer: immediate return to the reset values above, including enable_reading=0.

Test Plan:
- Single request: req0_en=1, addr=23'h000100, cnt=24'd4; reading_done rises 10 cycles after enable. Required response:
  - enable_reading within 2 cycles, with ddr3_rd_start_addr=0x100 and cnt=4.
  - req0_done=1, err=0, three cycles after reading_done (2 sync + 1).
  - Drop req0_en -> enable_reading stays 0; IDLE after done falls.
- Tie and round-robin: req0_en and req1_en both asserted from reset -> grant_id=0 first, then grant_id=1; a second simultaneous pair yields 0 then 1 again. No overlap of enable_reading between grants.
- Zero count: req1_en=1, cnt=0 -> enable_reading never asserts; req1_done=1, req1_err=1; timeout_count unchanged.
- Timeout: TIMEOUT_CYCLES=32, reading_done held 0 -> req0_done=1, req0_err=1 exactly 32 cycles after entering READ; timeout_count=1. Repeat 300 times -> saturates at 255.
- Async reset mid-READ: assert reset_n low while enable_reading=1 -> enable_reading, grant_valid, done and err all 0 without a clock edge. Next request after release grants requester 0.
- Late done while in DRAIN: hold reading_done high 20 cycles after req0_en drop -> no new grant until done_s falls. A pending req1 is then granted.
